// File: rtl/handshake_burst_tx.sv
// handshake_burst_tx: valid/ready burst source.
// A start command with a non-zero length emits that many beats of
// incrementing data, honouring downstream backpressure. Every output is
// driven straight from a register.
// Optional feature macro: HANDSHAKE_BURST_TX_CHECKSUM_EN appends one
// XOR-checksum beat (carrying last_o) after the payload beats.
module handshake_burst_tx #(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] seed_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // The gap counter counts down to zero, so it is loaded with one less than
  // the number of gap cycles to spend in GAP.
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  state_t             state;
  logic [LEN_W-1:0]   remaining;
  logic [7:0]         gap_cnt;
  logic               beat_xfer;
  logic               final_beat;

`ifdef HANDSHAKE_BURST_TX_CHECKSUM_EN
  logic [DATA_W-1:0]  csum;
  logic               csum_phase;
`endif

  // Transfer detection and identification of the beat that closes the burst.
  always_comb begin
    beat_xfer = valid_o & ready_i;
`ifdef HANDSHAKE_BURST_TX_CHECKSUM_EN
    final_beat = csum_phase;
`else
    final_beat = (remaining == LEN_W'(1));
`endif
  end

  // Burst FSM with registered handshake outputs and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      valid_o    <= 1'b0;
      data_o     <= '0;
      last_o     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      remaining  <= '0;
      gap_cnt    <= 8'd0;
`ifdef HANDSHAKE_BURST_TX_CHECKSUM_EN
      csum       <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i && (len_i != LEN_W'(0))) begin
            state     <= SEND;
            valid_o   <= 1'b1;
            data_o    <= seed_i;
            remaining <= len_i;
            busy_o    <= 1'b1;
`ifdef HANDSHAKE_BURST_TX_CHECKSUM_EN
            last_o     <= 1'b0;
            csum       <= '0;
            csum_phase <= 1'b0;
`else
            last_o    <= (len_i == LEN_W'(1));
`endif
          end
        end

        SEND: begin
          done_o <= 1'b0;
          if (beat_xfer) begin
            if (final_beat) begin
              // Burst complete: drop valid on the edge of the last transfer.
              valid_o <= 1'b0;
              last_o  <= 1'b0;
`ifdef HANDSHAKE_BURST_TX_CHECKSUM_EN
              csum_phase <= 1'b0;
`endif
              if (GAP_CYCLES == 0) begin
                state  <= IDLE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end else begin
                state   <= GAP;
                gap_cnt <= GAP_LOAD;
              end
            end
`ifdef HANDSHAKE_BURST_TX_CHECKSUM_EN
            else if (remaining == LEN_W'(1)) begin
              // Last payload beat gone: follow it directly with the checksum.
              data_o     <= csum ^ data_o;
              last_o     <= 1'b1;
              csum_phase <= 1'b1;
              remaining  <= '0;
            end
`endif
            else begin
              data_o    <= data_o + DATA_W'(1);
              remaining <= remaining - LEN_W'(1);
`ifdef HANDSHAKE_BURST_TX_CHECKSUM_EN
              csum      <= csum ^ data_o;
              last_o    <= 1'b0;
`else
              last_o    <= (remaining == LEN_W'(2));
`endif
            end
          end
        end

        GAP: begin
          if (gap_cnt == 8'd0) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        default: begin
          state   <= IDLE;
          valid_o <= 1'b0;
          last_o  <= 1'b0;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
